// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero padding, FCS append and
// inter-frame gap, steering an external CRC32 engine along the way.
`timescale 1ns/1ps
module eth_tx_framer #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG_LEN = 12,
  parameter int CRC_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        crc_init,
  output logic        crc_update,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_result,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        underrun,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, CRCW, FCS, IFG} state_t;

  // The wire path is CRC_LAT register stages deep while crc_data is one, so the
  // CRC result is ready exactly when the last data byte leaves the wire and the
  // FCS follows with no gap. The IFG wait is shortened by the same amount so the
  // idle time measured on the wire is IFG_LEN.
  localparam logic [7:0]  PRE_LAST  = 8'd6;
  localparam logic [7:0]  CRCW_LAST = 8'(CRC_LAT - 1);
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_LEN - CRC_LAT - 1);
  localparam logic [11:0] MIN_M1    = 12'(MIN_LEN - 1);
  localparam logic [11:0] MAX_M1    = 12'(MAX_LEN - 1);

  state_t      state, state_nxt;
  logic [11:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]  step_cnt, step_cnt_nxt;   // preamble, CRC wait, FCS index, IFG
  logic        drain, drain_nxt;         // discarding the tail of an aborted frame
  logic [31:0] fcs_q, fcs_nxt, fcs_now;
  logic [9:0]  pre_word;                 // {er, en, txd} entering the wire pipe
  logic        fcs_drive;
  logic [7:0]  fcs_byte;
  logic        s_ready_nxt, crc_init_nxt, crc_update_nxt, underrun_nxt;
  logic [7:0]  crc_data_nxt;
  logic [9:0]  wire_pipe [CRC_LAT];

  // FCS is the bit-reversed, inverted raw accumulator.
  always_comb begin
    for (int i = 0; i < 32; i++) fcs_now[i] = ~crc_result[31 - i];
  end

  // Next-state and next-output decode for the framing FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt      = state;
    byte_cnt_nxt   = byte_cnt;
    step_cnt_nxt   = step_cnt;
    drain_nxt      = drain;
    fcs_nxt        = fcs_q;
    pre_word       = '0;
    fcs_drive      = 1'b0;
    fcs_byte       = 8'h00;
    crc_init_nxt   = 1'b0;
    crc_update_nxt = 1'b0;
    crc_data_nxt   = 8'h00;
    underrun_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (s_valid) begin
          crc_init_nxt = 1'b1;
          byte_cnt_nxt = '0;
          step_cnt_nxt = '0;
          state_nxt    = PRE;
        end
      end
      PRE: begin
        pre_word = {2'b01, 8'h55};
        if (step_cnt == PRE_LAST) begin
          step_cnt_nxt = '0;
          state_nxt    = SFD;
        end else begin
          step_cnt_nxt = step_cnt + 8'd1;
        end
      end
      SFD: begin
        pre_word  = {2'b01, 8'hD5};
        state_nxt = DATA;
      end
      DATA: begin
        if (!s_valid || (byte_cnt == MAX_M1 && !s_last)) begin
          // Source starved or frame too long: flag the error on the wire and
          // swallow whatever remains of the frame before the gap starts.
          pre_word     = {2'b11, 8'h00};
          underrun_nxt = 1'b1;
          drain_nxt    = 1'b1;
          step_cnt_nxt = '0;
          state_nxt    = IFG;
        end else begin
          pre_word       = {2'b01, s_data};
          crc_update_nxt = 1'b1;
          crc_data_nxt   = s_data;
          byte_cnt_nxt   = byte_cnt + 12'd1;
          if (s_last) begin
            step_cnt_nxt = '0;
            state_nxt    = (byte_cnt < MIN_M1) ? PAD : CRCW;
          end
        end
      end
      PAD: begin
        pre_word       = {2'b01, 8'h00};
        crc_update_nxt = 1'b1;
        byte_cnt_nxt   = byte_cnt + 12'd1;
        if (byte_cnt == MIN_M1) begin
          step_cnt_nxt = '0;
          state_nxt    = CRCW;
        end
      end
      CRCW: begin
        if (step_cnt == CRCW_LAST) begin
          fcs_drive    = 1'b1;
          fcs_byte     = fcs_now[7:0];
          fcs_nxt      = fcs_now;
          step_cnt_nxt = 8'd1;
          state_nxt    = FCS;
        end else begin
          step_cnt_nxt = step_cnt + 8'd1;
        end
      end
      FCS: begin
        fcs_drive = 1'b1;
        case (step_cnt[1:0])
          2'd1:    fcs_byte = fcs_q[15:8];
          2'd2:    fcs_byte = fcs_q[23:16];
          default: fcs_byte = fcs_q[31:24];
        endcase
        if (step_cnt[1:0] == 2'd3) begin
          step_cnt_nxt = '0;
          state_nxt    = IFG;
        end else begin
          step_cnt_nxt = step_cnt + 8'd1;
        end
      end
      IFG: begin
        if (drain) begin
          if (s_valid && s_ready && s_last) drain_nxt = 1'b0;
        end else if (step_cnt == IFG_LAST) begin
          state_nxt = IDLE;
        end else begin
          step_cnt_nxt = step_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    s_ready_nxt = (state_nxt == DATA) || (state_nxt == IFG && drain_nxt);
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of its neighbours; the decode above uses blocking.
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      step_cnt   <= '0;
      drain      <= 1'b0;
      fcs_q      <= '0;
      s_ready    <= 1'b0;
      crc_init   <= 1'b0;
      crc_update <= 1'b0;
      crc_data   <= 8'h00;
      underrun   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      step_cnt   <= step_cnt_nxt;
      drain      <= drain_nxt;
      fcs_q      <= fcs_nxt;
      s_ready    <= s_ready_nxt;
      crc_init   <= crc_init_nxt;
      crc_update <= crc_update_nxt;
      crc_data   <= crc_data_nxt;
      underrun   <= underrun_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Wire delay line; the FCS bypasses it straight into the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small array drives output ports, so unlike a data-only
      // storage array it is reset to keep the wire quiet after reset.
      for (int i = 0; i < CRC_LAT; i++) wire_pipe[i] <= '0;
    end else begin
      wire_pipe[0] <= pre_word;
      for (int i = 1; i < CRC_LAT; i++) wire_pipe[i] <= wire_pipe[i - 1];
      if (fcs_drive) wire_pipe[CRC_LAT - 1] <= {2'b01, fcs_byte};
    end
  end

  assign {gmii_tx_er, gmii_tx_en, gmii_txd} = wire_pipe[CRC_LAT - 1];

endmodule
